reg_bank_sb: RTL and testbench
==============================

# reg_bank_sb

Parametrised general-purpose register bank for the pipelined core, with configurable width, depth and read-port count. Adds optional write-to-read bypass and an integrated scoreboard that tracks registers with an in-flight producer. Sits between decode (reads and busy marking) and writeback (write and busy release).

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of two, at least 2
- NRD, 2, number of read ports, 1..4
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports
- ZERO_REG, 1, when 1 register 0 is hardwired to zero and never busy

Derived: AW = $clog2(NREGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  writeback write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- ra  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- rbusy  out  NRD  port i address has a pending producer
- set_busy  in  1  issue marks a destination as pending
- set_addr  in  AW  destination being marked
- flush  in  1  clear all busy bits (pipeline flush)

## Operation
- **Storage.** NREGS x XLEN array plus an NREGS-bit busy vector.
- **Reset.** While rst is high at a clock edge, all registers are set to 0 and all busy bits to 0. rst takes priority over we, set_busy and flush. Reset asserted mid-operation discards any concurrent write or set.
- **Write.** At a clock edge with we=1, mem[wa] is set to wd. The write is ignored when ZERO_REG=1 and wa=0.
- **Read.** Reads are combinational.
  - rd[i] = 0 if ZERO_REG and ra[i]=0.
  - Otherwise, wd if BYPASS and we and wa=ra[i] and the write is not ignored.
  - Otherwise, mem[ra[i]].
- **Busy set/clear.**
  - we=1 clears busy[wa].
  - set_busy=1 sets busy[set_addr].
  - If both target the same address in the same cycle, set wins: a new producer is issued while the old one retires.
  - With ZERO_REG=1, busy[0] is never set.
- **Flush.** flush=1 clears every busy bit. If set_busy is also high in that cycle, its set still applies after the clear. Register contents are unaffected.
- **rbusy output.** rbusy[i] = busy[ra[i]], except it is forced to 0 when BYPASS and a non-ignored write to ra[i] occurs in the same cycle. With ZERO_REG=1, rbusy[i] is 0 for ra[i]=0.
- **Multiple read ports.** Any number of ports may read the same address; each gets identical data and busy.

## Timing
- Write-to-read latency:
  - 0 cycles with BYPASS=1 (same-cycle forward).
  - 1 cycle with BYPASS=0 (new value visible after the edge).
- Busy set visible on rbusy 1 cycle after set_busy. Clear by writeback is visible the same cycle when BYPASS=1, otherwise 1 cycle later.
- Output values after reset:
  - rd = 0 on every port.
  - rbusy = 0 on every port.
  - These hold until the first write or set.
- No handshake stalls. The block always accepts one write and one set per cycle.

## Structure
- Package reg_bank_pkg holds:
  - default XLEN and NREGS;
  - typedef reg_addr_t = logic [AW-1:0] for the default depth;
  - typedef xdata_t = logic [XLEN-1:0].
- Sub-module reg_scoreboard contains the busy vector, the set/clear/flush priority logic and the per-port rbusy generation. It is parametrised by NREGS, NRD, BYPASS and ZERO_REG.
- The top level instantiates reg_scoreboard and contains the storage array, the write logic and the read/bypass muxes.

## Test plan
- **Reset clears everything.** Write 0xDEADBEEF to reg 5, assert rst for 1 cycle, read ra0=5 → rd0=0 and rbusy0=0.
- **Zero register.** Write 0x12345678 to reg 0 with ZERO_REG=1 → rd=0 on the next cycle, and rd=0 in the same cycle (no bypass).
- **Bypass.** BYPASS=1, we=1, wa=7, wd=0xA5A5A5A5, ra1=7 → rd1=0xA5A5A5A5 in the same cycle. Repeat with BYPASS=0 → old value in that cycle, new value next cycle.
- **Busy lifecycle.** set_busy with set_addr=3 → rbusy for ra=3 is 1 next cycle. Writeback we=1, wa=3 → rbusy=0 in the same cycle (BYPASS=1).
- **Set vs. clear collision.** set_busy=1 with set_addr=9 and we=1 with wa=9 in the same cycle → busy[9]=1 afterwards and mem[9]=wd.
- **Flush and reset priority.** Set busy on regs 1, 2 and 3, then flush=1 with set_busy on reg 4 → only reg 4 is busy. Then rst=1 together with we to reg 4 → mem[4]=0 and busy[4]=0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared defaults and types for the general-purpose register bank.
// Storage and scoreboard modules take their parameter defaults from here.
package reg_bank_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

  // True when a write to this address actually lands in storage.
  function automatic logic write_lands(input logic we, input logic addr_is_zero,
                                       input logic zero_reg);
    return we && !(zero_reg && addr_is_zero);
  endfunction

endpackage

// File: rtl/reg_bank_sb_if.sv
// Decode/writeback side bundle of the register bank. There is no handshake:
// one write and one busy-set are accepted every cycle, reads are combinational.
interface reg_bank_sb_if
  import reg_bank_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                set_busy;
  logic [AW-1:0]       set_addr;
  logic                flush;

  modport master (
    output we, wa, wd, ra, set_busy, set_addr, flush,
    input  rd, rbusy
  );

  modport slave (
    input  we, wa, wd, ra, set_busy, set_addr, flush,
    output rd, rbusy
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy vector for registers with an in-flight producer, plus per-port
// rbusy generation including same-cycle writeback release.
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic              set_busy,
  input  logic [AW-1:0]     set_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]    rbusy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_ok;
  logic             set_ok;

  assign wr_ok  = write_lands(we, wa == '0, ZERO_REG != 0);
  assign set_ok = set_busy && !((ZERO_REG != 0) && set_addr == '0);

  // Order matters: flush, then writeback release, then set, so a new
  // producer always survives a retire or flush in the same cycle.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end
    if (we) begin
      busy_d[wa] = 1'b0;
    end
    if (set_ok) begin
      busy_d[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    logic [AW-1:0] a;
    a     = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      a        = ra[i*AW +: AW];
      rbusy[i] = busy_q[a];
      if ((BYPASS != 0) && wr_ok && (wa == a)) begin
        rbusy[i] = 1'b0;
      end
      if ((ZERO_REG != 0) && (a == '0)) begin
        rbusy[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_bank_sb.sv
// General-purpose register bank: storage, write port, read/bypass muxes,
// and an integrated scoreboard of registers awaiting writeback.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input logic          clk,
  input logic          rst,
  reg_bank_sb_if.slave bus
);

  logic [XLEN-1:0] mem [NREGS];
  logic            wr_ok;

  assign wr_ok = write_lands(bus.we, bus.wa == '0, ZERO_REG != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  // Zero register beats bypass so a write to r0 can never leak to a reader.
  always_comb begin
    logic [AW-1:0] a;
    a      = '0;
    bus.rd = '0;
    for (int i = 0; i < NRD; i++) begin
      a = bus.ra[i*AW +: AW];
      if ((ZERO_REG != 0) && (a == '0)) begin
        bus.rd[i*XLEN +: XLEN] = '0;
      end else if ((BYPASS != 0) && wr_ok && (bus.wa == a)) begin
        bus.rd[i*XLEN +: XLEN] = bus.wd;
      end else begin
        bus.rd[i*XLEN +: XLEN] = mem[a];
      end
    end
  end

  reg_scoreboard #(
    .NREGS   (NREGS),
    .NRD     (NRD),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.we),
    .wa      (bus.wa),
    .set_busy(bus.set_busy),
    .set_addr(bus.set_addr),
    .flush   (bus.flush),
    .ra      (bus.ra),
    .rbusy   (bus.rbusy)
  );

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed bench for reg_bank_sb: one bypassing and one non-bypassing
// instance driven with identical stimulus and checked against fixed values.
module tb_reg_bank_sb;
  import reg_bank_pkg::*;

  logic      clk;
  logic      rst;
  logic      we;
  reg_addr_t wa;
  xdata_t    wd;
  reg_addr_t ra0;
  reg_addr_t ra1;
  logic      set_busy;
  reg_addr_t set_addr;
  logic      flush;

  int checks;
  int errors;

  reg_bank_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_b ();
  reg_bank_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_n ();

  assign bus_b.we = we;       assign bus_n.we = we;
  assign bus_b.wa = wa;       assign bus_n.wa = wa;
  assign bus_b.wd = wd;       assign bus_n.wd = wd;
  assign bus_b.ra = {ra1, ra0};
  assign bus_n.ra = {ra1, ra0};
  assign bus_b.set_busy = set_busy;  assign bus_n.set_busy = set_busy;
  assign bus_b.set_addr = set_addr;  assign bus_n.set_addr = set_addr;
  assign bus_b.flush = flush;        assign bus_n.flush = flush;

  reg_bank_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );
  reg_bank_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0), .ZERO_REG(1)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire xdata_t rd0_b = bus_b.rd[31:0];
  wire xdata_t rd1_b = bus_b.rd[63:32];
  wire xdata_t rd0_n = bus_n.rd[31:0];
  wire xdata_t rd1_n = bus_n.rd[63:32];
  wire         rb0_b = bus_b.rbusy[0];
  wire         rb1_b = bus_b.rbusy[1];
  wire         rb0_n = bus_n.rbusy[0];
  wire         rb1_n = bus_n.rbusy[1];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0;
    set_busy = 1'b0; set_addr = '0; flush = 1'b0;
  endtask

  task automatic write_reg(input reg_addr_t a, input xdata_t d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic mark_busy(input reg_addr_t a);
    set_busy = 1'b1; set_addr = a;
    tick();
    set_busy = 1'b0;
  endtask

  task automatic test_reset();
    ra0 = 5'd5; ra1 = 5'd7;
    #1;
    checks++; if (rd0_b !== 32'h0 || rd1_b !== 32'h0) begin errors++;
      $display("FAIL reset_rd_b got %h/%h want 0/0", rd0_b, rd1_b); end
    checks++; if (rd0_n !== 32'h0 || rd1_n !== 32'h0) begin errors++;
      $display("FAIL reset_rd_n got %h/%h want 0/0", rd0_n, rd1_n); end
    checks++; if ({rb1_b, rb0_b, rb1_n, rb0_n} !== 4'b0000) begin errors++;
      $display("FAIL reset_rbusy got %b want 0000", {rb1_b, rb0_b, rb1_n, rb0_n}); end
    write_reg(5'd5, 32'hDEADBEEF);
    checks++; if (rd0_n !== 32'hDEADBEEF) begin errors++;
      $display("FAIL pre_reset_write got %h want deadbeef", rd0_n); end
    mark_busy(5'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rd0_b !== 32'h0 || rd0_n !== 32'h0) begin errors++;
      $display("FAIL reset_clears_rd got %h/%h want 0/0", rd0_b, rd0_n); end
    checks++; if (rb0_b !== 1'b0 || rb0_n !== 1'b0) begin errors++;
      $display("FAIL reset_clears_busy got %b/%b want 0/0", rb0_b, rb0_n); end
  endtask

  task automatic test_zero_reg();
    ra0 = 5'd0; ra1 = 5'd0;
    we = 1'b1; wa = 5'd0; wd = 32'h12345678;
    set_busy = 1'b1; set_addr = 5'd0;
    #1;
    checks++; if (rd0_b !== 32'h0 || rd0_n !== 32'h0) begin errors++;
      $display("FAIL zero_same_cycle got %h/%h want 0/0", rd0_b, rd0_n); end
    tick();
    idle();
    #1;
    checks++; if (rd0_b !== 32'h0 || rd1_n !== 32'h0) begin errors++;
      $display("FAIL zero_next_cycle got %h/%h want 0/0", rd0_b, rd1_n); end
    checks++; if (rb0_b !== 1'b0 || rb0_n !== 1'b0) begin errors++;
      $display("FAIL zero_never_busy got %b/%b want 0/0", rb0_b, rb0_n); end
  endtask

  task automatic test_bypass();
    write_reg(5'd7, 32'h11111111);
    ra0 = 5'd0; ra1 = 5'd7;
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5;
    #1;
    checks++; if (rd1_b !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL bypass_fwd got %h want a5a5a5a5", rd1_b); end
    checks++; if (rd1_n !== 32'h11111111) begin errors++;
      $display("FAIL nobypass_old got %h want 11111111", rd1_n); end
    tick();
    we = 1'b0;
    #1;
    checks++; if (rd1_b !== 32'hA5A5A5A5 || rd1_n !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL bypass_next_cycle got %h/%h want a5a5a5a5", rd1_b, rd1_n); end
  endtask

  task automatic test_busy_lifecycle();
    ra0 = 5'd3; ra1 = 5'd3;
    set_busy = 1'b1; set_addr = 5'd3;
    #1;
    checks++; if (rb0_b !== 1'b0 || rb0_n !== 1'b0) begin errors++;
      $display("FAIL busy_not_yet got %b/%b want 0/0", rb0_b, rb0_n); end
    tick();
    set_busy = 1'b0;
    #1;
    checks++; if ({rb1_b, rb0_b, rb1_n, rb0_n} !== 4'b1111) begin errors++;
      $display("FAIL busy_set got %b want 1111", {rb1_b, rb0_b, rb1_n, rb0_n}); end
    we = 1'b1; wa = 5'd3; wd = 32'h33333333;
    #1;
    checks++; if (rb0_b !== 1'b0 || rb0_n !== 1'b1) begin errors++;
      $display("FAIL busy_release_same got b=%b n=%b want b=0 n=1", rb0_b, rb0_n); end
    tick();
    we = 1'b0;
    #1;
    checks++; if (rb0_b !== 1'b0 || rb0_n !== 1'b0) begin errors++;
      $display("FAIL busy_release_next got %b/%b want 0/0", rb0_b, rb0_n); end
  endtask

  task automatic test_collision();
    ra0 = 5'd9; ra1 = 5'd9;
    we = 1'b1; wa = 5'd9; wd = 32'hCAFEF00D;
    set_busy = 1'b1; set_addr = 5'd9;
    #1;
    checks++; if (rd0_b !== 32'hCAFEF00D || rb0_b !== 1'b0) begin errors++;
      $display("FAIL collide_same got %h/%b want cafef00d/0", rd0_b, rb0_b); end
    tick();
    idle();
    #1;
    checks++; if (rd0_b !== 32'hCAFEF00D || rd1_n !== 32'hCAFEF00D) begin errors++;
      $display("FAIL collide_data got %h/%h want cafef00d", rd0_b, rd1_n); end
    checks++; if ({rb1_b, rb0_b, rb1_n, rb0_n} !== 4'b1111) begin errors++;
      $display("FAIL collide_set_wins got %b want 1111", {rb1_b, rb0_b, rb1_n, rb0_n}); end
  endtask

  task automatic test_multi_port();
    write_reg(5'd12, 32'h0BADC0DE);
    mark_busy(5'd12);
    ra0 = 5'd12; ra1 = 5'd12;
    #1;
    checks++; if (rd0_b !== 32'h0BADC0DE || rd1_b !== 32'h0BADC0DE) begin errors++;
      $display("FAIL multi_rd got %h/%h want 0badc0de", rd0_b, rd1_b); end
    checks++; if (rb0_n !== 1'b1 || rb1_n !== 1'b1) begin errors++;
      $display("FAIL multi_busy got %b/%b want 1/1", rb0_n, rb1_n); end
  endtask

  task automatic test_flush_and_reset();
    mark_busy(5'd1);
    mark_busy(5'd2);
    mark_busy(5'd3);
    ra0 = 5'd2; ra1 = 5'd3;
    #1;
    checks++; if (rb0_b !== 1'b1 || rb1_n !== 1'b1) begin errors++;
      $display("FAIL flush_pre got %b/%b want 1/1", rb0_b, rb1_n); end
    flush = 1'b1; set_busy = 1'b1; set_addr = 5'd4;
    tick();
    idle();
    ra0 = 5'd1; ra1 = 5'd2;
    #1;
    checks++; if ({rb1_b, rb0_b, rb1_n, rb0_n} !== 4'b0000) begin errors++;
      $display("FAIL flush_clear12 got %b want 0000", {rb1_b, rb0_b, rb1_n, rb0_n}); end
    ra0 = 5'd3; ra1 = 5'd4;
    #1;
    checks++; if (rb0_b !== 1'b0 || rb1_b !== 1'b1 || rb1_n !== 1'b1) begin errors++;
      $display("FAIL flush_keep4 got r3=%b r4=%b/%b want 0 1/1", rb0_b, rb1_b, rb1_n); end
    ra0 = 5'd9; ra1 = 5'd12;
    #1;
    checks++; if (rb0_b !== 1'b0 || rb1_n !== 1'b0 || rd1_n !== 32'h0BADC0DE) begin errors++;
      $display("FAIL flush_keeps_data got %b/%b %h want 0/0 0badc0de", rb0_b, rb1_n, rd1_n); end
    ra0 = 5'd4; ra1 = 5'd4;
    rst = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'h77777777;
    set_busy = 1'b1; set_addr = 5'd4;
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (rd0_b !== 32'h0 || rd0_n !== 32'h0) begin errors++;
      $display("FAIL rst_beats_write got %h/%h want 0/0", rd0_b, rd0_n); end
    checks++; if (rb0_b !== 1'b0 || rb0_n !== 1'b0) begin errors++;
      $display("FAIL rst_beats_set got %b/%b want 0/0", rb0_b, rb0_n); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ra0 = '0; ra1 = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_zero_reg();
    test_bypass();
    test_busy_lifecycle();
    test_collision();
    test_multi_port();
    test_flush_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
